// File: rtl/uart_mmio.sv
// uart_mmio: memory-mapped 8N1 UART on SoC data port B, with TX and RX byte FIFOs.
// Register map (relative to BASE_ADDR): +0 IN READY, +1 OUT READY, +2 DATA.
// Build option: define UART_LOOPBACK_EN to feed uart_tx back into the receiver
// (uart_rx is then ignored; the uart_tx pin still toggles).

module uart_mmio_fifo #(
  parameter int unsigned AW = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] wdata,
  input  logic       pop,
  output logic [7:0] head_c,
  output logic       empty_c,
  output logic       full_c
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  // Pointers carry an extra wrap bit so equal indices can mean empty or full.
  assign empty_c = (wr_ptr == rd_ptr);
  assign full_c  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign head_c  = mem[rd_ptr[AW-1:0]];

  // Pop on empty is a no-op; a push into a full FIFO lands only if a pop frees a slot.
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);

  // Pointer update.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

module uart_mmio #(
  parameter int unsigned BASE_ADDR    = 65537,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_AW      = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_b,
  input  logic [31:0] data_b_in,
  input  logic        data_b_we,
  output logic [31:0] data_b,
  output logic        strobe_b,
  input  logic        uart_rx,
  output logic        uart_tx
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [31:0]   ADDR_IN     = 32'(BASE_ADDR);
  localparam logic [31:0]   ADDR_OUT    = 32'(BASE_ADDR + 1);
  localparam logic [31:0]   ADDR_DATA   = 32'(BASE_ADDR + 2);
  localparam logic [CW-1:0] BIT_RELOAD  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_RELOAD = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  // ---------------- bus decode ----------------
  logic        sel_in;
  logic        sel_out;
  logic        sel_data;
  logic [31:0] prev_addr_b;
  logic        prev_rd;
  logic        first_rd;
  logic        rx_pop;
  logic        ovr_clr;
  logic        tx_push;
  logic        unused_wdata;

  assign sel_in   = (addr_b == ADDR_IN);
  assign sel_out  = (addr_b == ADDR_OUT);
  assign sel_data = (addr_b == ADDR_DATA);
  assign strobe_b = sel_in || sel_out || sel_data;

  // A read side effect fires only on the first cycle of a run of reads to the same address,
  // so a stalled CPU holding the address pops or clears exactly once.
  assign first_rd = !data_b_we && !(prev_rd && (prev_addr_b == addr_b));
  assign rx_pop   = sel_data && first_rd;
  assign ovr_clr  = sel_in && first_rd;
  assign tx_push  = sel_data && data_b_we;

  assign unused_wdata = ^data_b_in[31:8];

  // Remember last cycle's address and whether it was a read.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_addr_b <= '0;
      prev_rd     <= 1'b0;
    end else begin
      prev_addr_b <= addr_b;
      prev_rd     <= !data_b_we;
    end
  end

  // ---------------- FIFOs ----------------
  logic [7:0] tx_head;
  logic       tx_empty;
  logic       tx_full;
  logic       tx_pop;
  logic [7:0] rx_head;
  logic       rx_empty;
  logic       rx_full;
  logic       rx_push;
  logic [7:0] rx_shift;

  uart_mmio_fifo #(.AW(FIFO_AW)) u_tx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tx_push),
    .wdata   (data_b_in[7:0]),
    .pop     (tx_pop),
    .head_c  (tx_head),
    .empty_c (tx_empty),
    .full_c  (tx_full)
  );

  uart_mmio_fifo #(.AW(FIFO_AW)) u_rx_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (rx_push),
    .wdata   (rx_shift),
    .pop     (rx_pop),
    .head_c  (rx_head),
    .empty_c (rx_empty),
    .full_c  (rx_full)
  );

  // ---------------- read data mux ----------------
  logic overrun;

  // Zero-latency read data; zero whenever the address is not ours.
  always_comb begin
    data_b = '0;
    if (sel_in) begin
      data_b = {30'b0, overrun, !rx_empty};
    end else if (sel_out) begin
      data_b = {31'b0, !tx_full};
    end else if (sel_data && !rx_empty) begin
      data_b = {24'b0, rx_head};
    end
  end

  // ---------------- transmitter ----------------
  state_t        tx_state;
  logic [CW-1:0] tx_cnt;
  logic [2:0]    tx_bit;
  logic [7:0]    tx_shift;
  logic          tx_bit_end;

  assign tx_bit_end = (tx_cnt == '0);
  // Load a new byte from IDLE, or straight out of STOP so back-to-back frames have no gap.
  assign tx_pop = !tx_empty && ((tx_state == S_IDLE) || ((tx_state == S_STOP) && tx_bit_end));

  // TX frame sequencer; uart_tx is registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= S_IDLE;
      tx_cnt   <= '0;
      tx_bit   <= '0;
      tx_shift <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_pop) begin
            tx_shift <= tx_head;
            tx_cnt   <= BIT_RELOAD;
            uart_tx  <= 1'b0;
            tx_state <= S_START;
          end
        end
        S_START: begin
          if (tx_bit_end) begin
            tx_cnt   <= BIT_RELOAD;
            tx_bit   <= '0;
            uart_tx  <= tx_shift[0];
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (tx_bit_end) begin
            tx_cnt <= BIT_RELOAD;
            if (tx_bit == 3'd7) begin
              uart_tx  <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_bit   <= tx_bit + 3'd1;
              tx_shift <= {1'b0, tx_shift[7:1]};
              uart_tx  <= tx_shift[1];
            end
          end else begin
            tx_cnt <= tx_cnt - CW'(1);
          end
        end
        S_STOP: begin
          if (tx_bit_end) begin
            if (tx_pop) begin
              tx_shift <= tx_head;
              tx_cnt   <= BIT_RELOAD;
              uart_tx  <= 1'b0;
              tx_state <= S_START;
            end else begin
              tx_state <= S_IDLE;
            end
          end else begin
            tx_cnt <= tx_cnt - CW'(1);
          end
        end
        default: begin
          uart_tx  <= 1'b1;
          tx_state <= S_IDLE;
        end
      endcase
    end
  end

  // ---------------- receiver ----------------
  logic rx_line;

`ifdef UART_LOOPBACK_EN
  logic unused_rx;
  assign rx_line   = uart_tx;
  assign unused_rx = uart_rx;
`else
  assign rx_line = uart_rx;
`endif

  logic rx_s1;
  logic rx_s2;
  logic rx_s3;

  // Two-flop synchroniser plus one delayed copy for falling-edge detection; idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= rx_line;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  state_t        rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    rx_bit;
  logic          rx_bit_end;

  assign rx_bit_end = (rx_cnt == '0);
  // A good stop bit queues the byte; a low stop bit (framing error) drops it.
  assign rx_push = (rx_state == S_STOP) && rx_bit_end && rx_s2;

  // RX frame sequencer: half-bit to the start-bit centre, then one bit period per sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= S_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_shift <= '0;
    end else begin
      case (rx_state)
        S_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_cnt   <= HALF_RELOAD;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_bit_end) begin
            if (rx_s2) begin
              rx_state <= S_IDLE;
            end else begin
              rx_cnt   <= BIT_RELOAD;
              rx_bit   <= '0;
              rx_state <= S_DATA;
            end
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (rx_bit_end) begin
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_cnt   <= BIT_RELOAD;
            if (rx_bit == 3'd7) begin
              rx_state <= S_STOP;
            end else begin
              rx_bit <= rx_bit + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        S_STOP: begin
          if (rx_bit_end) begin
            rx_state <= S_IDLE;
          end else begin
            rx_cnt <= rx_cnt - CW'(1);
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  // Overrun latches when a good byte finds the RX FIFO full; a new overrun beats a clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      overrun <= 1'b0;
    end else if (rx_push && rx_full && !rx_pop) begin
      overrun <= 1'b1;
    end else if (ovr_clr) begin
      overrun <= 1'b0;
    end
  end

endmodule
